// File: rtl/restoring_divider.sv
// restoring_divider
//   Multi-cycle unsigned divider for the datapath ALU. Restoring
//   shift-and-subtract, one trial subtraction per clock, WIDTH iterations
//   per operation. One operand pair is taken per start/done handshake.
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1 in
//   IDLE captures A/B and raises busy. busy stays high for WIDTH cycles,
//   then done pulses for exactly one cycle with Q/R/Z/V freshly loaded.
//   start seen in RUN or DONE is ignored. busy and done are never high
//   together.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : request a division (IDLE only)
//   A, B     : dividend / divisor, unsigned, captured on the accepting edge
//   busy     : operation in progress (RUN)
//   done     : one-cycle completion pulse
//   Q, R     : quotient / remainder, held until the next completion
//   Z        : quotient is zero
//   V        : divide-by-zero (captured B was 0)
//   dbgState : current FSM state (0 IDLE, 1 RUN, 2 DONE)
module restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             Z,
   output logic             V,
   output logic [1:0]       dbgState
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT            state;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   workRem;
   logic [WIDTH-1:0] workQuo;
   logic [CW-1:0]    iterCnt;

   logic [WIDTH:0]   remShift;
   logic [WIDTH:0]   trialDiff;
   logic [WIDTH:0]   remNext;
   logic [WIDTH-1:0] quoNext;

   // One restoring step. The working remainder is always below the divisor
   // after a step (or, for B=0, is a prefix of A), so its low WIDTH bits
   // carry everything needed for the next shift.
   always_comb begin
      remShift  = {workRem[WIDTH-1:0], dividend[WIDTH-1]};
      trialDiff = remShift - {1'b0, divisor};
      remNext   = remShift;
      quoNext   = workQuo << 1;
      if (!trialDiff[WIDTH]) begin
         remNext = trialDiff;
         quoNext = (workQuo << 1) | WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dividend <= '0;
         divisor  <= '0;
         workRem  <= '0;
         workQuo  <= '0;
         iterCnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Q        <= '0;
         R        <= '0;
         Z        <= 1'b0;
         V        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dividend <= A;
                  divisor  <= B;
                  workRem  <= '0;
                  workQuo  <= '0;
                  iterCnt  <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               workRem  <= remNext;
               workQuo  <= quoNext;
               dividend <= dividend << 1;
               iterCnt  <= iterCnt + 1'b1;
               if (iterCnt == CW'(WIDTH - 1)) begin
                  // Last iteration: publish results from the step values.
                  Q     <= quoNext;
                  R     <= remNext[WIDTH-1:0];
                  Z     <= (quoNext == '0);
                  V     <= (divisor == '0);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign dbgState = state;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] R;
   logic             Z;
   logic             V;
   logic [1:0]       dbgState;

   int nChecks = 0;
   int nErrors = 0;

   restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Q(Q), .R(R), .Z(Z), .V(V),
      .dbgState(dbgState)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Drive start with operands so the next rising edge accepts them; returns
   // #1 after that accepting edge (edge 0).
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic hold);
      @(negedge clk);
      start = 1'b1;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Called #1 after the accepting edge. Counts edges until done, and how
   // many of the sampled cycles (including the one after edge 0) had busy.
   task automatic waitDone(output int cyc, output int busyCnt, output int overlap);
      cyc = 0;
      busyCnt = busy ? 1 : 0;
      overlap = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (busy && done) overlap++;
         if (busy) busyCnt++;
         if (done) break;
      end
   endtask

   task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input logic ez, input logic ev, input logic full);
      int cyc, busyCnt, overlap;
      issue(a, b, 1'b0);
      A = ~a;  // operands may change freely after acceptance
      B = ~b;
      waitDone(cyc, busyCnt, overlap);
      chk({tag, ".Q"}, Q, eq);
      chk({tag, ".R"}, R, er);
      chk({tag, ".Z"}, Z, ez);
      chk({tag, ".V"}, V, ev);
      if (full) begin
         chk({tag, ".latency"}, cyc, WIDTH);
         chk({tag, ".busyCycles"}, busyCnt, WIDTH);
         chk({tag, ".overlap"}, overlap, 0);
         @(posedge clk);
         #1;
         chk({tag, ".doneFall"}, done, 0);
         chk({tag, ".idle"}, dbgState, 0);
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int cyc, busyCnt, overlap, pulses;
      logic [WIDTH-1:0] mq, mr;

      // reset
      rst = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.Q", Q, 0);
      chk("rst.R", R, 0);
      chk("rst.Z", Z, 0);
      chk("rst.V", V, 0);
      chk("rst.state", dbgState, 0);
      rst = 1'b0;

      // directed vectors
      runOp("d13_4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b0, 1'b1);
      runOp("d3_5", 4'd3, 4'd5, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1);
      runOp("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b0, 1'b1, 1'b1);

      // back-to-back with start held high; operands change during RUN
      issue(4'd15, 4'd1, 1'b1);
      A = 4'd0;
      B = 4'd7;
      waitDone(cyc, busyCnt, overlap);
      chk("b2b1.latency", cyc, WIDTH);
      chk("b2b1.Q", Q, 15);
      chk("b2b1.R", R, 0);
      chk("b2b1.Z", Z, 0);
      @(posedge clk);  // edge 5: DONE -> IDLE, start ignored
      #1;
      chk("b2b.gapBusy", busy, 0);
      chk("b2b.gapState", dbgState, 0);
      @(posedge clk);  // edge 6: second accept
      #1;
      chk("b2b2.accept", busy, 1);
      start = 1'b0;
      waitDone(cyc, busyCnt, overlap);
      chk("b2b2.latency", cyc, WIDTH);
      chk("b2b2.Q", Q, 0);
      chk("b2b2.R", R, 0);
      chk("b2b2.Z", Z, 1);
      chk("b2b2.V", V, 0);
      @(posedge clk);
      #1;

      // reset mid-operation
      issue(4'd13, 4'd4, 1'b0);  // edge 0
      @(posedge clk);           // edge 1
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);           // edge 2
      #1;
      rst = 1'b0;
      chk("abort.busy", busy, 0);
      chk("abort.done", done, 0);
      chk("abort.Q", Q, 0);
      chk("abort.R", R, 0);
      chk("abort.Z", Z, 0);
      chk("abort.V", V, 0);
      chk("abort.state", dbgState, 0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      chk("abort.noDone", pulses, 0);
      runOp("afterAbort", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b0, 1'b1);

      // exhaustive sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) begin
               mq = 4'd15;
               mr = WIDTH'(a);
            end else begin
               mq = WIDTH'(a / b);
               mr = WIDTH'(a % b);
            end
            runOp($sformatf("sw%0d_%0d", a, b), WIDTH'(a), WIDTH'(b), mq, mr,
                  mq == 0, b == 0, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Multi-cycle unsigned integer divider for the datapath ALU. It computes quotient and remainder by restoring shift-and-subtract, one trial subtraction per cycle. It reports Z/V status flags in the same style as the combinational adder/subtractor flags. It takes one operand pair per start/done handshake and sits beside the adder/subtractor as the ALU's division unit.

## Interface
- `WIDTH`, default 4: bit width of dividend, divisor, quotient and remainder.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a division. Sampled only in IDLE.
- `A` input WIDTH: dividend, unsigned. Captured on the accepting edge.
- `B` input WIDTH: divisor, unsigned. Captured on the accepting edge.
- `busy` output 1: high while an operation is in progress (RUN state).
- `done` output 1: one-cycle pulse; Q/R/Z/V are valid and newly updated.
- `Q` output WIDTH: quotient. Held until the next completion.
- `R` output WIDTH: remainder. Held until the next completion.
- `Z` output 1: quotient equals zero.
- `V` output 1: divide-by-zero (B was 0).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 captures A into the dividend shift register and B into the divisor register.
  - Clears the working remainder (WIDTH+1 bits) and the working quotient, sets the iteration counter to 0, and moves to RUN.
- RUN, once per cycle:
  - Shift the working remainder left by 1, bringing in the dividend MSB; shift the dividend left by 1.
  - Trial difference D = remainder − divisor, computed at WIDTH+1 bits.
  - If D ≥ 0 (MSB clear): remainder ← D and the quotient LSB is 1. Otherwise the remainder is kept and the quotient LSB is 0.
  - The quotient shifts left each iteration.
  - After WIDTH iterations (counter == WIDTH−1 on that edge), move to DONE.
  - On that same edge, load Q, R (low WIDTH bits), Z = (quotient==0) and V = (captured B==0).
- DONE: `done`=1 for exactly one cycle, then unconditional return to IDLE. `start` in DONE is ignored.
- Divide-by-zero: no special path. The algorithm naturally yields Q = all ones and R = A, and V=1. Latency is identical to the normal case.
- `start` while busy or in DONE is ignored; the captured operands are not disturbed.
- A and B may change freely after the accepting edge.
- Q/R/Z/V change only on the completion edge or on reset. They never expose intermediate values.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, Q=0, R=0, Z=0, V=0, counter and working registers 0.
- Reset takes priority over every other action. Reset during RUN or DONE aborts the operation with no `done` pulse.
- Edge 0 accepts `start`; `busy`=1 from edge 0 through edge WIDTH.
- Iterations occur on edges 1..WIDTH. Outputs update and `done`=1 after edge WIDTH; `done` falls after edge WIDTH+1.
- Earliest next accept is at edge WIDTH+2, giving throughput of one operation per WIDTH+2 cycles.
- `busy` and `done` are never high together.

## Test plan
- WIDTH=4, A=13, B=4, start at edge 0 -> `done` after edge 4 with Q=3, R=1, Z=0, V=0; `busy` high for exactly 4 cycles.
- A=3, B=5 -> Q=0, R=3, Z=1, V=0.
- A=9, B=0 -> Q=15, R=9, V=1, Z=0, same latency as the normal case.
- A=15, B=1, then back-to-back start held high with A=0, B=7 -> first result Q=15, R=0. Second operation is accepted at edge 6, giving Q=0, R=0, Z=1. Start pulses during RUN/DONE are ignored and operands are not re-captured.
- Start A=13, B=4, assert `rst` at edge 2 -> no `done` pulse. All outputs are 0 and the state is IDLE after the reset edge, and a fresh start then completes correctly.
- Exhaustive sweep of all 256 A/B pairs at WIDTH=4 against a reference model (A/B, A%B, B=0 -> Q=15, R=A) -> all match.
